calendar_seq: RTL and testbench

// Sequencer for the calendar datapath: day, month and year counters (Year has end_of_year/offset edge inputs).

---
 rtl/calendar_seq.sv | 213 +++++++++++++++++++++
 tb/tb_calendar_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_seq.sv
// Calendar sequencer: turns the midnight tick and user set-mode buttons into ordered,
// single-cycle advance/clear/load pulses for the day, month and year counters.
module calendar_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       day_tick,
    input  logic       set_en,
    input  logic       sel_btn,
    input  logic       inc_btn,
    input  logic [4:0] day,
    input  logic [3:0] month,
    input  logic       leap_year,
    output logic       day_inc,
    output logic       day_clr,
    output logic       day_load,
    output logic [4:0] day_load_val,
    output logic       month_inc,
    output logic       month_clr,
    output logic       end_of_year,
    output logic       year_offset,
    output logic [1:0] field,
    output logic       busy
);

    localparam int CNT_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ROLL_MONTH,
        SETTLE,
        CLAMP,
        GAP
    } state_t;

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = leap ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] next_field(input logic [1:0] f);
        return (f >= 2'd2) ? 2'd0 : f + 2'd1;
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pending, pending_n;
    logic             sel_q, inc_q;
    logic             sel_rise, inc_rise;
    logic [4:0]       dim;

    logic             day_inc_n, day_clr_n, day_load_n;
    logic [4:0]       day_load_val_n;
    logic             month_inc_n, month_clr_n, end_of_year_n, year_offset_n;
    logic [1:0]       field_n;

    assign sel_rise = sel_btn & ~sel_q;
    assign inc_rise = inc_btn & ~inc_q;
    assign dim      = days_in_month(month, leap_year);

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        pending_n      = pending;
        field_n        = field;
        day_inc_n      = 1'b0;
        day_clr_n      = 1'b0;
        day_load_n     = 1'b0;
        day_load_val_n = 5'd0;
        month_inc_n    = 1'b0;
        month_clr_n    = 1'b0;
        end_of_year_n  = 1'b0;
        year_offset_n  = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!set_en) begin
                    if (day_tick || pending) begin
                        pending_n = 1'b0;
                        if (day < dim) begin
                            day_inc_n = 1'b1;
                            state_n   = GAP;
                        end else begin
                            day_clr_n = 1'b1;
                            state_n   = ROLL_MONTH;
                        end
                    end
                end else begin
                    // Ticks arriving during user edits are discarded, including a queued one.
                    pending_n = 1'b0;
                    if (sel_rise) begin
                        field_n = next_field(field);
                    end
                    if (inc_rise) begin
                        case (field)
                            2'd0: begin
                                if (day < dim) day_inc_n = 1'b1;
                                else           day_clr_n = 1'b1;
                                state_n = GAP;
                            end
                            2'd1: begin
                                if (month < 4'd12) month_inc_n = 1'b1;
                                else               month_clr_n = 1'b1;
                                state_n = SETTLE;
                            end
                            default: begin
                                year_offset_n = 1'b1;
                                state_n       = SETTLE;
                            end
                        endcase
                    end
                end
            end

            ROLL_MONTH: begin
                if (month < 4'd12) begin
                    month_inc_n = 1'b1;
                end else begin
                    month_clr_n   = 1'b1;
                    end_of_year_n = 1'b1;
                end
                cnt_n   = '0;
                state_n = GAP;
            end

            SETTLE: begin
                // Give the month/year counters and the leap flag time to reflect the edit.
                if (cnt == SETTLE_LAST) begin
                    cnt_n   = '0;
                    state_n = CLAMP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            CLAMP: begin
                if (day > dim) begin
                    day_load_n     = 1'b1;
                    day_load_val_n = dim;
                end
                cnt_n   = '0;
                state_n = GAP;
            end

            GAP: begin
                // The entry cycle carries the last pulse; GAP_CYCLES quiet cycles follow it.
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        if ((state != IDLE) && !set_en && day_tick) begin
            pending_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            pending      <= 1'b0;
            sel_q        <= 1'b0;
            inc_q        <= 1'b0;
            field        <= 2'd0;
            busy         <= 1'b0;
            day_inc      <= 1'b0;
            day_clr      <= 1'b0;
            day_load     <= 1'b0;
            day_load_val <= 5'd0;
            month_inc    <= 1'b0;
            month_clr    <= 1'b0;
            end_of_year  <= 1'b0;
            year_offset  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pending      <= pending_n;
            sel_q        <= sel_btn;
            inc_q        <= inc_btn;
            field        <= field_n;
            busy         <= (state_n != IDLE);
            day_inc      <= day_inc_n;
            day_clr      <= day_clr_n;
            day_load     <= day_load_n;
            day_load_val <= day_load_val_n;
            month_inc    <= month_inc_n;
            month_clr    <= month_clr_n;
            end_of_year  <= end_of_year_n;
            year_offset  <= year_offset_n;
        end
    end

endmodule

// File: tb/tb_calendar_seq.sv
// Bench for calendar_seq: a behavioural calendar (day/month/year counters) reacts to the
// sequencer's pulses; results are compared against hand-computed dates and pulse patterns.
module tb_calendar_seq;

    localparam logic [6:0] P_DINC = 7'b1000000;
    localparam logic [6:0] P_DCLR = 7'b0100000;
    localparam logic [6:0] P_DLD  = 7'b0010000;
    localparam logic [6:0] P_MINC = 7'b0001000;
    localparam logic [6:0] P_MCLR = 7'b0000100;
    localparam logic [6:0] P_EOY  = 7'b0000010;
    localparam logic [6:0] P_YOFF = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       day_tick = 1'b0;
    logic       set_en = 1'b0;
    logic       sel_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [4:0] day;
    logic [3:0] month;
    logic       leap_year;
    logic       day_inc, day_clr, day_load, month_inc, month_clr, end_of_year, year_offset;
    logic [4:0] day_load_val;
    logic [1:0] field;
    logic       busy;

    calendar_seq #(.SETTLE_CYCLES(2), .GAP_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .day_tick(day_tick), .set_en(set_en),
        .sel_btn(sel_btn), .inc_btn(inc_btn), .day(day), .month(month),
        .leap_year(leap_year), .day_inc(day_inc), .day_clr(day_clr),
        .day_load(day_load), .day_load_val(day_load_val), .month_inc(month_inc),
        .month_clr(month_clr), .end_of_year(end_of_year), .year_offset(year_offset),
        .field(field), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural calendar counters driven by the sequencer's pulses.
    logic       load_en = 1'b1;
    logic [4:0] ld_day = 5'd1;
    logic [3:0] ld_month = 4'd1;
    int         ld_year = 2025;
    logic [4:0] day_m = 5'd1;
    logic [3:0] month_m = 4'd1;
    int         year_m = 2025;

    assign day       = day_m;
    assign month     = month_m;
    assign leap_year = ((year_m % 4) == 0) && (((year_m % 100) != 0) || ((year_m % 400) == 0));

    always @(posedge clk) begin
        if (load_en) begin
            day_m   <= ld_day;
            month_m <= ld_month;
            year_m  <= ld_year;
        end else begin
            if (day_inc)       day_m <= day_m + 5'd1;
            else if (day_clr)  day_m <= 5'd1;
            else if (day_load) day_m <= day_load_val;
            if (month_inc)      month_m <= month_m + 4'd1;
            else if (month_clr) month_m <= 4'd1;
            if (end_of_year || year_offset) year_m <= year_m + 1;
        end
    end

    typedef struct {
        logic [3:0] month;
        logic [4:0] day;
        int         year;
        logic [6:0] c1;
        logic [6:0] c2;
        int         busy_len;
        logic [4:0] f_day;
        logic [3:0] f_month;
        int         f_year;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic logic [6:0] pulses();
        return {day_inc, day_clr, day_load, month_inc, month_clr, end_of_year, year_offset};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic load_date(input logic [3:0] m, input logic [4:0] d, input int y);
        @(negedge clk);
        load_en  = 1'b1;
        ld_month = m;
        ld_day   = d;
        ld_year  = y;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic press_sel();
        @(negedge clk);
        sel_btn = 1'b1;
        @(negedge clk);
        sel_btn = 1'b0;
    endtask

    // Press inc, report the first response cycle and what happens until busy drops.
    task automatic do_inc(output logic [6:0] first, output int n_load,
                          output int load_val, output int n_yoff);
        @(negedge clk);
        inc_btn = 1'b1;
        @(negedge clk);
        inc_btn  = 1'b0;
        first    = pulses();
        n_load   = 0;
        load_val = 0;
        n_yoff   = 0;
        for (int c = 0; c < 20; c++) begin
            if (day_load) begin
                n_load++;
                load_val = int'(day_load_val);
            end
            if (year_offset) n_yoff++;
            if (!busy) break;
            @(negedge clk);
        end
        check("inc_busy_done", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] g1, g2, first, acc;
        int         blen, nl, lv, ny, n_dinc, n_mon;

        vecs[0] = '{4'd3,  5'd14, 2025, P_DINC, 7'd0,            2, 5'd15, 4'd3,  2025};
        vecs[1] = '{4'd12, 5'd31, 2025, P_DCLR, P_MCLR | P_EOY,  3, 5'd1,  4'd1,  2026};
        vecs[2] = '{4'd2,  5'd28, 2024, P_DINC, 7'd0,            2, 5'd29, 4'd2,  2024};
        vecs[3] = '{4'd2,  5'd28, 2025, P_DCLR, P_MINC,          3, 5'd1,  4'd3,  2025};
        vecs[4] = '{4'd2,  5'd29, 2024, P_DCLR, P_MINC,          3, 5'd1,  4'd3,  2024};
        vecs[5] = '{4'd4,  5'd30, 2025, P_DCLR, P_MINC,          3, 5'd1,  4'd5,  2025};
        vecs[6] = '{4'd1,  5'd30, 2025, P_DINC, 7'd0,            2, 5'd31, 4'd1,  2025};
        vecs[7] = '{4'd6,  5'd30, 2025, P_DCLR, P_MINC,          3, 5'd1,  4'd7,  2025};

        repeat (3) @(negedge clk);
        check("rst_pulses", int'(pulses()), 0);
        check("rst_field", int'(field), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_load_val", int'(day_load_val), 0);
        reset   = 1'b0;
        load_en = 1'b0;

        // Midnight rollover vectors
        for (int i = 0; i < 8; i++) begin
            load_date(vecs[i].month, vecs[i].day, vecs[i].year);
            day_tick = 1'b1;
            @(negedge clk);
            day_tick = 1'b0;
            g1   = pulses();
            g2   = 7'd0;
            blen = 0;
            for (int c = 0; c < 20; c++) begin
                if (c == 1) g2 = pulses();
                if (!busy) break;
                blen++;
                @(negedge clk);
            end
            check($sformatf("v%0d_first_pulse", i), int'(g1), int'(vecs[i].c1));
            check($sformatf("v%0d_second_pulse", i), int'(g2), int'(vecs[i].c2));
            check($sformatf("v%0d_busy_len", i), blen, vecs[i].busy_len);
            check($sformatf("v%0d_day", i), int'(day_m), int'(vecs[i].f_day));
            check($sformatf("v%0d_month", i), int'(month_m), int'(vecs[i].f_month));
            check($sformatf("v%0d_year", i), year_m, vecs[i].f_year);
        end

        // Set mode: month edit with clamp Jan 31 -> Feb 28
        set_en = 1'b1;
        load_date(4'd1, 5'd31, 2025);
        press_sel();
        check("sel_field1", int'(field), 1);
        do_inc(first, nl, lv, ny);
        check("mon_first", int'(first), int'(P_MINC));
        check("mon_nload", nl, 1);
        check("mon_load_val", lv, 28);
        check("mon_day", int'(day_m), 28);
        check("mon_month", int'(month_m), 2);

        // Set mode: year edit with clamp Feb 29 2024 -> Feb 28 2025
        press_sel();
        check("sel_field2", int'(field), 2);
        load_date(4'd2, 5'd29, 2024);
        do_inc(first, nl, lv, ny);
        check("yr_first", int'(first), int'(P_YOFF));
        check("yr_offset_cycles", ny, 1);
        check("yr_nload", nl, 1);
        check("yr_load_val", lv, 28);
        check("yr_year", year_m, 2025);
        check("yr_day", int'(day_m), 28);

        // Field wraps to day; day edit at month end clears
        press_sel();
        check("sel_wrap0", int'(field), 0);
        do_inc(first, nl, lv, ny);
        check("dayf_first", int'(first), int'(P_DCLR));
        check("dayf_nload", nl, 0);
        check("dayf_day", int'(day_m), 1);

        // sel and inc together: inc acts on the old field (day), field advances
        @(negedge clk);
        sel_btn = 1'b1;
        inc_btn = 1'b1;
        @(negedge clk);
        sel_btn = 1'b0;
        inc_btn = 1'b0;
        check("both_pulse", int'(pulses()), int'(P_DINC));
        check("both_field", int'(field), 1);
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("both_day", int'(day_m), 2);

        // Month edit with no clamp needed
        load_date(4'd3, 5'd15, 2025);
        do_inc(first, nl, lv, ny);
        check("noclamp_first", int'(first), int'(P_MINC));
        check("noclamp_nload", nl, 0);
        check("noclamp_date", int'(month_m) * 100 + int'(day_m), 415);

        // Tick during set mode is dropped and not queued
        @(negedge clk);
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
        acc = 7'd0;
        for (int c = 0; c < 6; c++) begin
            acc = acc | pulses() | {6'd0, busy};
            @(negedge clk);
        end
        set_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            acc = acc | pulses() | {6'd0, busy};
            @(negedge clk);
        end
        check("setmode_tick_drop", int'(acc), 0);
        check("setmode_tick_day", int'(day_m), 15);

        // Tick while busy is queued and serviced after the gap
        load_date(4'd3, 5'd14, 2025);
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
        n_dinc = 0;
        for (int c = 0; c < 12; c++) begin
            day_tick = (c == 1);
            if (day_inc) n_dinc++;
            @(negedge clk);
        end
        day_tick = 1'b0;
        check("pending_dinc_count", n_dinc, 2);
        check("pending_day", int'(day_m), 16);
        check("pending_idle", int'(busy), 0);

        // Reset asserted during ROLL_MONTH
        check("pre_reset_field", int'(field), 1);
        load_date(4'd4, 5'd30, 2025);
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
        check("rr_day_clr", int'(pulses()), int'(P_DCLR));
        #1 reset = 1'b1;
        #1;
        check("rr_pulses_drop", int'(pulses()), 0);
        check("rr_busy_drop", int'(busy), 0);
        check("rr_field_drop", int'(field), 0);
        @(negedge clk);
        reset = 1'b0;
        n_mon = 0;
        acc   = 7'd0;
        for (int c = 0; c < 6; c++) begin
            if (month_inc || month_clr) n_mon++;
            acc = acc | pulses();
            @(negedge clk);
        end
        check("rr_no_month_pulse", n_mon, 0);
        check("rr_no_pulse", int'(acc), 0);
        check("rr_month", int'(month_m), 4);
        check("rr_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
